// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: baud selects, divisors, frame shape, FSM states
package uart_pkg;

  localparam int DIV_SEL0   = 109;
  localparam int DIV_SEL1   = 54;
  localparam int DIV_SEL2   = 18;
  localparam int DIV_SEL3   = 9;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam int DIV_MAX = (DIV_SEL0 > DIV_SEL1) ?
                           ((DIV_SEL0 > DIV_SEL2) ? ((DIV_SEL0 > DIV_SEL3) ? DIV_SEL0 : DIV_SEL3)
                                                  : ((DIV_SEL2 > DIV_SEL3) ? DIV_SEL2 : DIV_SEL3))
                         : ((DIV_SEL1 > DIV_SEL2) ? ((DIV_SEL1 > DIV_SEL3) ? DIV_SEL1 : DIV_SEL3)
                                                  : ((DIV_SEL2 > DIV_SEL3) ? DIV_SEL2 : DIV_SEL3));
  localparam int DIV_W   = $clog2(DIV_MAX);

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_STOP      = 3'd3;
  localparam uart_state_t ST_WAIT_HIGH = 3'd4;

  // Terminal count (divisor minus one) for a baud select.
  function automatic logic [DIV_W-1:0] div_last(input logic [1:0] sel);
    case (sel)
      BAUD_9600:   div_last = DIV_W'(DIV_SEL0 - 1);
      BAUD_19200:  div_last = DIV_W'(DIV_SEL1 - 1);
      BAUD_57600:  div_last = DIV_W'(DIV_SEL2 - 1);
      default:     div_last = DIV_W'(DIV_SEL3 - 1);
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample enable generator with divisor latched on restart
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] baud_sel,
  input  logic       restart,
  output logic       tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // Restart zeroes the phase so sampling lines up with the start-bit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= div_last(BAUD_9600);
      cnt   <= '0;
    end else if (restart) begin
      div_q <= div_last(baud_sel);
      cnt   <= '0;
    end else if (cnt == div_q) begin
      cnt   <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == div_q) && !restart;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and selectable baud rate
module uart_rx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           baud_sel,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [1:0]           fill_cnt;
  logic                 armed;
  uart_state_t          state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The synchroniser resets high, so the line must be seen genuinely high
  // before a low level may count as a start bit (e.g. reset in mid-frame).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      if (fill_cnt != 2'd2) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  assign restart = (state == ST_IDLE) && armed && !rx_s;
  assign busy    = (state != ST_IDLE);

  uart_baud_tick u_tick (
    .clk      (clk),
    .reset    (reset),
    .baud_sel (baud_sel),
    .restart  (restart),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (restart) begin
            state  <= ST_START;
            os_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_cnt == OS_HALF) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= ST_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              data   <= shift;
              if (rx_s) begin
                data_valid <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
